apb_master_ctrl: RTL and testbench

//  Synthesizable, parametrised APB3 master for the watchdog subsystem and its testbench.

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_wait_timer.sv | 42 ++++
 rtl/apb_master_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB3 master controller.
//   apb_state_e : transfer FSM states
//   apb_rsp_t   : captured response payload {rdata, err, timeout}
//   sel_w()     : width of the slave-select index vector (at least 1 bit)
package apb_pkg;

  // Response payload data width; the master's DATA_W must match it.
  localparam int unsigned APB_RSP_DATA_W = 8;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_RSP_DATA_W-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_t;

  // $clog2(nsel), widened to 1 so a single-slave build still has a legal vector.
  function automatic int unsigned sel_w(input int unsigned nsel);
    return (nsel > 1) ? $clog2(nsel) : 1;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait counter with bounded-wait expiry.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count at zero (wins over en)
//   en         : one more wait cycle elapsed
//   expire_c   : this enabled cycle brings the count to TIMEOUT_MAX
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, increment, or hold at TIMEOUT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_W'(TIMEOUT_MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Flags the cycle whose increment would land on TIMEOUT_MAX.
  assign expire_c = en && !clr && (cnt_q == CNT_W'(TIMEOUT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 master: takes one command at a time over valid/ready, runs a
// SETUP/ACCESS transfer with wait states, slave error and timeout abort,
// decodes psel over NSEL slaves, and returns a one-cycle response pulse.
//   pclk, preset_n        : clock, async active-low reset
//   cmd_valid/cmd_ready   : command handshake (cmd_ready high only in IDLE)
//   cmd_write/addr/wdata  : command payload
//   rsp_valid             : one-cycle response strobe
//   rsp_rdata/err/timeout : response payload, held until the next response
//   psel/penable/pwrite/paddr/pwdata : APB request side
//   prdata/pready/pslverr : APB completion side
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NSEL        = 1,
  parameter int unsigned TIMEOUT_MAX = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [NSEL-1:0]   psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int unsigned SEL_W = sel_w(NSEL);

  // The response struct carries a fixed-width data field.
  if (DATA_W != APB_RSP_DATA_W) begin : g_width_guard
    $error("apb_master_ctrl: DATA_W must equal apb_pkg::APB_RSP_DATA_W");
  end

  apb_state_e        state_q,     state_d;
  logic [NSEL-1:0]   psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  apb_rsp_t          rsp_q,       rsp_d;

  logic [SEL_W-1:0]  sel_idx_c;
  logic              sel_ok_c;
  logic [NSEL-1:0]   sel_onehot_c;
  logic              tmr_clr_c;
  logic              tmr_en_c;
  logic              tmr_expire_c;

  // Slave index comes from the top address bits; a single slave uses none.
  if (NSEL > 1) begin : g_sel_dec
    assign sel_idx_c = cmd_addr[ADDR_W-1 -: SEL_W];
  end else begin : g_sel_one
    assign sel_idx_c = '0;
  end

  assign sel_ok_c     = (32'(sel_idx_c) < NSEL);
  assign sel_onehot_c = NSEL'(1) << sel_idx_c;

  apb_wait_timer #(
    .TIMEOUT_MAX (TIMEOUT_MAX)
  ) u_wait_timer (
    .clk      (pclk),
    .rst_n    (preset_n),
    .clr      (tmr_clr_c),
    .en       (tmr_en_c),
    .expire_c (tmr_expire_c)
  );

  // Transfer FSM: next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_d       = rsp_q;
    tmr_clr_c   = 1'b0;
    tmr_en_c    = 1'b0;

    unique case (state_q)
      APB_IDLE: begin
        if (cmd_valid) begin
          if (sel_ok_c) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
            psel_d   = sel_onehot_c;
            state_d  = APB_SETUP;
          end else begin
            // Unmapped slave: answer with an error, never touch the bus.
            rsp_d       = '{rdata: '0, err: 1'b1, timeout: 1'b0};
            rsp_valid_d = 1'b1;
            state_d     = APB_RESP;
          end
        end
      end

      APB_SETUP: begin
        penable_d = 1'b1;
        tmr_clr_c = 1'b1;
        state_d   = APB_ACCESS;
      end

      APB_ACCESS: begin
        if (pready) begin
          // Read data is only returned for a clean read.
          rsp_d.rdata   = (pwrite_q || pslverr) ? '0 : prdata;
          rsp_d.err     = pslverr;
          rsp_d.timeout = 1'b0;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = APB_RESP;
        end else begin
          tmr_en_c = 1'b1;
          if (tmr_expire_c) begin
            rsp_d       = '{rdata: '0, err: 1'b1, timeout: 1'b1};
            psel_d      = '0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = APB_RESP;
          end
        end
      end

      APB_RESP: begin
        state_d = APB_IDLE;
      end

      default: begin
        state_d = APB_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= APB_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign cmd_ready   = (state_q == APB_IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: three slaves (select = addr[7:6]),
// TIMEOUT_MAX of 4, table of transfers plus a mid-transfer reset sequence.
module tb_apb_master_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NSEL   = 3;
  localparam int unsigned TMAX   = 4;

  logic              pclk = 1'b0;
  logic              preset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [NSEL-1:0]   psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  always #5 pclk = ~pclk;

  apb_master_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NSEL        (NSEL),
    .TIMEOUT_MAX (TMAX)
  ) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  // wait_n: ACCESS cycle index at which pready rises; tmo: pready never rises.
  // e_acc: expected number of ACCESS cycles (penable high).
  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         wait_n;
    logic       tmo;
    logic [7:0] prdata;
    logic       slverr;
    logic [2:0] e_psel;
    int         e_acc;
    logic [7:0] e_rdata;
    logic       e_err;
    logic       e_to;
  } vec_t;

  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  // Runs one table entry; starts and ends on a falling edge with the DUT idle.
  task automatic run_vec(input int i);
    vec_t  v;
    string t;
    v = vecs[i];
    t = $sformatf("v%0d", i);
    chk({t, " idle_ready"}, 32'(cmd_ready), 32'(1'b1));
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = v.prdata;
    tick();
    // Keep offering conflicting commands while busy; they must be ignored.
    cmd_write = ~v.wr;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    if (v.e_psel == 3'b000) begin
      chk({t, " badsel_rsp_valid"}, 32'(rsp_valid), 32'(1'b1));
      chk({t, " badsel_psel"},      32'(psel),      32'(3'b000));
      chk({t, " badsel_penable"},   32'(penable),   32'(1'b0));
    end else begin
      chk({t, " setup_psel"},    32'(psel),      32'(v.e_psel));
      chk({t, " setup_penable"}, 32'(penable),   32'(1'b0));
      chk({t, " setup_paddr"},   32'(paddr),     32'(v.addr));
      chk({t, " setup_pwrite"},  32'(pwrite),    32'(v.wr));
      chk({t, " setup_pwdata"},  32'(pwdata),    32'(v.wdata));
      chk({t, " setup_rsp"},     32'(rsp_valid), 32'(1'b0));
      tick();
      for (int c = 0; c < v.e_acc; c++) begin
        chk($sformatf("%s acc%0d_penable", t, c), 32'(penable),   32'(1'b1));
        chk($sformatf("%s acc%0d_psel", t, c),    32'(psel),      32'(v.e_psel));
        chk($sformatf("%s acc%0d_paddr", t, c),   32'(paddr),     32'(v.addr));
        chk($sformatf("%s acc%0d_rsp", t, c),     32'(rsp_valid), 32'(1'b0));
        pready  = !v.tmo && (c == v.wait_n);
        pslverr = pready ? v.slverr : 1'b0;
        tick();
      end
      chk({t, " resp_rsp_valid"}, 32'(rsp_valid), 32'(1'b1));
      chk({t, " resp_psel"},      32'(psel),      32'(3'b000));
      chk({t, " resp_penable"},   32'(penable),   32'(1'b0));
    end
    chk({t, " resp_rdata"},   32'(rsp_rdata),   32'(v.e_rdata));
    chk({t, " resp_err"},     32'(rsp_err),     32'(v.e_err));
    chk({t, " resp_timeout"}, 32'(rsp_timeout), 32'(v.e_to));
    chk({t, " resp_ready"},   32'(cmd_ready),   32'(1'b0));
    cmd_valid = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    tick();
    chk({t, " pulse_end"},    32'(rsp_valid),   32'(1'b0));
    chk({t, " back_ready"},   32'(cmd_ready),   32'(1'b1));
    chk({t, " hold_rdata"},   32'(rsp_rdata),   32'(v.e_rdata));
    chk({t, " hold_err"},     32'(rsp_err),     32'(v.e_err));
    chk({t, " hold_timeout"}, 32'(rsp_timeout), 32'(v.e_to));
    if (v.e_psel != 3'b000) begin
      chk({t, " hold_paddr"},  32'(paddr),  32'(v.addr));
      chk({t, " hold_pwrite"}, 32'(pwrite), 32'(v.wr));
    end
  endtask

  initial begin
    //           wr    addr   wdata  wait tmo   prdata slverr psel    acc rdata  err   to
    vecs[0] = '{1'b1, 8'h10, 8'hA5, 0,   1'b0, 8'h77, 1'b0,  3'b001, 1,  8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h04, 8'h00, 3,   1'b0, 8'h3C, 1'b0,  3'b001, 4,  8'h3C, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h20, 8'h00, 0,   1'b1, 8'h55, 1'b0,  3'b001, 4,  8'h00, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 8'h08, 8'h00, 0,   1'b0, 8'h99, 1'b1,  3'b001, 1,  8'h00, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'hC0, 8'h00, 0,   1'b0, 8'h00, 1'b0,  3'b000, 0,  8'h00, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h80, 8'h00, 1,   1'b0, 8'h81, 1'b0,  3'b100, 2,  8'h81, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h55, 8'h45, 2,   1'b0, 8'hEE, 1'b1,  3'b010, 3,  8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h7F, 8'h00, 3,   1'b0, 8'hE1, 1'b0,  3'b010, 4,  8'hE1, 1'b0, 1'b0};

    preset_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_psel",      32'(psel),        32'(3'b000));
    chk("rst_penable",   32'(penable),     32'(1'b0));
    chk("rst_rsp_valid", 32'(rsp_valid),   32'(1'b0));
    chk("rst_rsp_err",   32'(rsp_err),     32'(1'b0));
    chk("rst_paddr",     32'(paddr),       32'(8'h00));
    preset_n = 1'b1;
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready),   32'(1'b1));

    for (int i = 0; i < 8; i++) begin
      run_vec(i);
    end

    // Reset during ACCESS of a write to slave 1: everything clears at once.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h45;
    cmd_wdata = 8'h5A;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid_penable", 32'(penable), 32'(1'b1));
    chk("mid_psel",    32'(psel),    32'(3'b010));
    preset_n = 1'b0;
    pready   = 1'b1;
    #1;
    chk("arst_psel",      32'(psel),        32'(3'b000));
    chk("arst_penable",   32'(penable),     32'(1'b0));
    chk("arst_pwrite",    32'(pwrite),      32'(1'b0));
    chk("arst_paddr",     32'(paddr),       32'(8'h00));
    chk("arst_pwdata",    32'(pwdata),      32'(8'h00));
    chk("arst_rsp_rdata", 32'(rsp_rdata),   32'(8'h00));
    chk("arst_rsp_valid", 32'(rsp_valid),   32'(1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("arst_hold%0d_rsp_valid", k), 32'(rsp_valid), 32'(1'b0));
    end
    preset_n = 1'b1;
    pready   = 1'b0;
    tick();
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
    chk("post_rst_ready",     32'(cmd_ready), 32'(1'b1));
    run_vec(0);
    run_vec(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
